pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end that owns the architectural PC register and drives the instruction memory. It consumes the next-PC value produced by the branch/jump unit as a redirect. It issues word requests to the instruction memory over a req/ack handshake and presents fetched instructions to decode through a one-entry valid/ready buffer. Its current PC feeds back into the next-PC unit.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction memory word 0.
- IM_AW, 12, instruction memory word-address width (4*2^IM_AW bytes).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- redirect_valid  input  1  one-cycle pulse; load redirect_pc as the new fetch PC.
- redirect_pc  input  32  target from the next-PC unit (branch/jal/jr).
- pc  output  32  current fetch PC (next address to request).
- pc_plus4  output  32  pc + 4, combinational.
- im_req  output  1  instruction memory request.
- im_addr  output  IM_AW  word address of the outstanding request.
- im_ack  input  1  memory completion; im_rdata is valid in the same cycle.
- im_rdata  input  32  instruction word.
- instr_valid  output  1  instr/instr_pc hold a fetched instruction.
- instr_ready  input  1  decode accepts instr this cycle.
- instr  output  32  fetched instruction.
- instr_pc  output  32  byte PC of instr.
- pc_fault  output  1  sticky; fetch PC left the instruction memory window.

## Operation
- State machine:
  - IDLE: reset state, one cycle; then goes to REQ.
  - REQ: issues fetches.
  - DRAIN: waits out an orphaned request.
  - FAULT: terminal until reset.
- Issue condition in REQ: im_req = 1 when the buffer is empty or is being emptied this cycle (!instr_valid || instr_ready), or when a request is already outstanding.
- The request address is registered in req_addr at issue as (pc - IM_BASE)[IM_AW+1:2]. im_addr = req_addr, and it is held stable while im_req=1 until im_ack.
- Once raised, im_req stays high until im_ack, regardless of instr_ready.
- Completion (im_ack while in REQ, no redirect this cycle):
  - instr <= im_rdata, instr_pc <= PC of the request, instr_valid <= 1.
  - pc <= pc + 4, arithmetic modulo 2^32.
- Buffer: instr_valid clears on instr_ready with no new completion. With a completion in the same cycle, the buffer is overwritten and stays valid.
- Redirect (redirect_valid=1), in any state except FAULT:
  - pc <= {redirect_pc[31:2], 2'b00}; low two bits are silently forced to zero.
  - instr_valid <= 0. A same-cycle instr_ready handshake still counts as a transfer.
  - im_ack in the same cycle: the data is discarded and the state stays REQ.
  - Request outstanding without ack: go to DRAIN.
- DRAIN:
  - im_req stays 1 with the old req_addr.
  - On im_ack, the data is discarded and the state goes to REQ.
  - A further redirect in DRAIN only updates pc.
- Fault check: before issuing, pc must satisfy IM_BASE <= pc < IM_BASE + 4*2^IM_AW.
  - On violation, no request is issued; the state goes to FAULT and pc_fault <= 1.
  - In FAULT: im_req=0, instr_valid=0 after the current buffer entry is consumed, and redirects are ignored.
- Reset mid-operation: all state returns to reset values at the next edge. An outstanding request is abandoned; memory is required to tolerate a dropped request.

## Timing
- Reset values:
  - pc = PC_RESET, state = IDLE, req_addr = 0.
  - im_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, pc_fault = 0.
- im_req first rises one cycle after reset deasserts.
- Zero-wait memory (im_ack in the cycle im_req rises): instr_valid rises on the next edge.
  - Sustained throughput is 1 instruction/cycle with instr_ready held high.
- N-cycle memory: instr_valid rises on the edge after im_ack.
- Redirect-to-first-request latency:
  - 1 cycle when no request is outstanding.
  - 1 cycle after the orphaned ack when draining.
- Redirect target instruction appears at the earliest 1 cycle after its im_ack.
- pc_plus4 and im_req are combinational from registered state and instr_valid/instr_ready. im_addr comes from a register.

## Test plan
- Reset then zero-wait memory, instr_ready=1:
  - im_addr = 0,1,2… on consecutive cycles.
  - instr_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles; pc_fault = 0.
- Backpressure: instr_ready=0 for 3 cycles after the first instruction.
  - instr_valid stays 1 and instr_pc stays 0x3000.
  - No second request issues until instr_ready=1.
- Redirect to 0x3040 on the same cycle as an im_ack for 0x3008.
  - The 0x3008 data is dropped.
  - Next im_addr = 0x10; next instr_pc = 0x3040.
- Memory with 3-cycle latency, redirect to 0x3100 one cycle after issue.
  - im_req stays high with the old address until the ack, and that data is discarded.
  - Then im_addr = 0x40.
- redirect_pc = 0x0000_2FFC.
  - No request issues; pc_fault = 1 next cycle and stays 1.
  - A later redirect to 0x3000 is ignored; reset clears the fault.
- redirect_pc = 0x3013: pc becomes 0x3010 and im_addr = 0x4.

Source files
------------

// File: rtl/pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch : PC register, I-mem req/ack fetch, one-entry decode buffer     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic             im_ack,
    input  logic [31:0]      im_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             pc_fault
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_REQ     = 2'd1;
    localparam logic [1:0]  S_DRAIN   = 2'd2;
    localparam logic [1:0]  S_FAULT   = 2'd3;
    localparam logic [32:0] WIN_BYTES = 33'd1 << (IM_AW + 2);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [IM_AW-1:0] req_addr_q, req_addr_d;
    logic             req_out_q, req_out_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      instr_pc_q, instr_pc_d;
    logic             fault_q, fault_d;

    logic [31:0]      w_off;
    logic [31:0]      w_off_d;
    logic             w_in_range;
    logic             w_req;
    logic [31:0]      w_redir_pc;

    assign w_off      = pc_q - IM_BASE;
    assign w_in_range = (pc_q >= IM_BASE) && ({1'b0, w_off} < WIN_BYTES);
    assign w_redir_pc = redirect_pc & ~32'h3;

    // Once a request is raised it is held until acked, whatever decode does.
    always_comb begin
        w_req = 1'b0;
        case (state_q)
            S_REQ:   w_req = req_out_q || ((!valid_q || instr_ready) && w_in_range);
            S_DRAIN: w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_out_d  = req_out_q;
        valid_d    = valid_q && !instr_ready;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = w_redir_pc;
            end
            S_REQ: begin
                if (!req_out_q && !w_in_range) begin
                    state_d   = S_FAULT;
                    fault_d   = 1'b1;
                    req_out_d = 1'b0;
                end else if (redirect_valid) begin
                    pc_d      = w_redir_pc;
                    valid_d   = 1'b0;
                    req_out_d = 1'b0;
                    if (w_req && !im_ack) state_d = S_DRAIN;
                end else if (w_req && im_ack) begin
                    instr_d    = im_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    req_out_d  = 1'b0;
                end else begin
                    req_out_d = w_req;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) pc_d = w_redir_pc;
                if (im_ack) state_d = S_REQ;
            end
            default: ;
        endcase
    end

    // req_addr tracks the next PC so a zero-wait issue already sees a registered address.
    assign w_off_d    = pc_d - IM_BASE;
    assign req_addr_d = (w_req && !im_ack) ? req_addr_q : IM_AW'(w_off_d >> 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RESET;
            req_addr_q <= '0;
            req_out_q  <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_out_q  <= req_out_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign im_req      = w_req;
    assign im_addr     = req_addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_fetch : randomized bench with behavioural fetch model and memory  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pc_fetch;

    localparam logic [31:0] IM_BASE = 32'h0000_3000;
    localparam int          IM_AW   = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic [31:0]      pc, pc_plus4;
    logic             im_req;
    logic [IM_AW-1:0] im_addr;
    logic             im_ack = 1'b0;
    logic [31:0]      im_rdata = '0;
    logic             instr_valid;
    logic             instr_ready = 1'b0;
    logic [31:0]      instr, instr_pc;
    logic             pc_fault;

    pc_fetch #(.PC_RESET(32'h0000_3000), .IM_BASE(IM_BASE), .IM_AW(IM_AW)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(pc), .pc_plus4(pc_plus4),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc_fault(pc_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // memory behaviour
    int  fix_lat = 0;
    bit  mem_busy = 0;
    int  mem_cnt = 0;
    int  mem_lat = 0;

    // reference model of the fetch unit
    bit               m_known = 0, m_started = 0, m_drain = 0, m_out = 0, m_fault = 0, m_bufv = 0;
    logic [31:0]      m_pc = '0, m_buf = '0, m_bufpc = '0;
    logic [IM_AW-1:0] m_raddr = '0;

    // snapshot of DUT outputs for the current cycle
    logic [31:0]      s_pc, s_ipc;
    logic             s_req, s_ivalid, s_fault;
    logic [IM_AW-1:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [IM_AW-1:0] a);
        return 32'hA500_0000 ^ ({20'd0, a} * 32'h9E37_79B1);
    endfunction

    function automatic bit inr(input logic [31:0] p);
        return (p >= IM_BASE) && ({32'd0, p} < ({32'd0, IM_BASE} + (64'd4 << IM_AW)));
    endfunction

    function automatic logic [IM_AW-1:0] word_of(input logic [31:0] p);
        logic [31:0] off;
        off = (p - IM_BASE) >> 2;
        return off[IM_AW-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        logic ereq;
        logic [IM_AW-1:0] eaddr;
        logic [31:0] al;
        @(negedge clk);
        reset = r; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy; im_ack = 1'b0;
        #1;
        if (im_req) begin
            if (!mem_busy) begin
                mem_busy = 1; mem_cnt = 0;
                mem_lat = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 3);
            end
            if (mem_cnt == mem_lat) begin
                im_ack = 1'b1; mem_busy = 0;
            end else mem_cnt++;
        end else mem_busy = 0;
        im_rdata = im_ack ? mem_word(im_addr) : $urandom;
        #1;
        s_pc = pc; s_req = im_req; s_addr = im_addr; s_ivalid = instr_valid;
        s_ipc = instr_pc; s_fault = pc_fault;

        if (!m_started || m_fault) ereq = 1'b0;
        else if (m_drain)          ereq = 1'b1;
        else                       ereq = m_out || ((!m_bufv || rdy) && inr(m_pc));
        eaddr = (m_drain || m_out) ? m_raddr : word_of(m_pc);
        al = rp & ~32'h3;

        if (m_known) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("im_req", {31'd0, im_req}, {31'd0, ereq});
            if (ereq) check("im_addr", {20'd0, im_addr}, {20'd0, eaddr});
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_bufv});
            if (m_bufv) begin
                check("instr", instr, m_buf);
                check("instr_pc", instr_pc, m_bufpc);
            end
            check("pc_fault", {31'd0, pc_fault}, {31'd0, m_fault});
        end

        if (r) begin
            m_known = 1; m_started = 0; m_drain = 0; m_out = 0; m_fault = 0; m_bufv = 0;
            m_pc = 32'h0000_3000; m_buf = '0; m_bufpc = '0;
        end else if (!m_started) begin
            m_started = 1;
            if (rv) m_pc = al;
        end else if (m_fault) begin
            if (rdy) m_bufv = 0;
        end else if (m_drain) begin
            if (rv) m_pc = al;
            if (im_ack) m_drain = 0;
        end else if (!m_out && !inr(m_pc)) begin
            m_fault = 1;
            if (rdy) m_bufv = 0;
        end else begin
            if (ereq && !m_out) m_raddr = word_of(m_pc);
            if (rv) begin
                m_pc = al; m_bufv = 0; m_out = 0;
                if (ereq && !im_ack) m_drain = 1;
            end else if (ereq && im_ack) begin
                m_buf = im_rdata; m_bufpc = m_pc; m_bufv = 1; m_pc = m_pc + 32'd4; m_out = 0;
            end else begin
                if (rdy) m_bufv = 0;
                m_out = ereq;
            end
        end
    endtask

    task automatic rst2();
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] rp;
        // Zero-wait sequential fetch
        fix_lat = 0;
        rst2();
        check("rst_pc", s_pc, 32'h0000_3000);
        check("rst_valid", {31'd0, s_ivalid}, 32'd0);
        check("rst_req", {31'd0, s_req}, 32'd0);
        check("rst_fault", {31'd0, s_fault}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("idle_req", {31'd0, s_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1);
            if (k < 3) check("seq_addr", {20'd0, s_addr}, k);
            if (k > 0) check("seq_ipc", s_ipc, 32'h0000_3000 + 4 * (k - 1));
        end
        check("seq_fault", {31'd0, s_fault}, 32'd0);

        // Backpressure
        rst2();
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            check("bp_valid", {31'd0, s_ivalid}, 32'd1);
            check("bp_ipc", s_ipc, 32'h0000_3000);
            check("bp_req", {31'd0, s_req}, 32'd0);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("bp_resume_req", {31'd0, s_req}, 32'd1);
        check("bp_resume_addr", {20'd0, s_addr}, 32'd1);

        // Redirect coinciding with the ack for 0x3008
        rst2();
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_3040, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("rd_pc", s_pc, 32'h0000_3040);
        check("rd_addr", {20'd0, s_addr}, 32'h10);
        check("rd_drop", {31'd0, s_ivalid}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("rd_ipc", s_ipc, 32'h0000_3040);

        // Redirect while a 3-cycle request is outstanding
        fix_lat = 3;
        rst2();
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_3100, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("dr_req", {31'd0, s_req}, 32'd1);
        check("dr_old_addr", {20'd0, s_addr}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("dr_new_addr", {20'd0, s_addr}, 32'h40);
        check("dr_discard", {31'd0, s_ivalid}, 32'd0);

        // Unaligned redirect
        fix_lat = 0;
        rst2();
        cyc(1'b0, 1'b1, 32'h0000_3013, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("ua_pc", s_pc, 32'h0000_3010);
        check("ua_addr", {20'd0, s_addr}, 32'h4);

        // Out-of-window redirect
        rst2();
        cyc(1'b0, 1'b1, 32'h0000_2FFC, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("flt_noreq", {31'd0, s_req}, 32'd0);
        cyc(1'b0, 1'b1, 32'h0000_3000, 1'b1);
        check("flt_set", {31'd0, s_fault}, 32'd1);
        check("flt_noreq2", {31'd0, s_req}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("flt_sticky", {31'd0, s_fault}, 32'd1);
        check("flt_ignore", s_pc, 32'h0000_2FFC);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("flt_clear", {31'd0, s_fault}, 32'd0);
        check("flt_clear_pc", s_pc, 32'h0000_3000);

        // Randomized traffic
        fix_lat = -1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0)
                rp = ($urandom_range(0, 1) == 0) ? IM_BASE - 4 * $urandom_range(1, 8)
                                                  : IM_BASE + (32'd4 << IM_AW) + $urandom_range(0, 15);
            else if ($urandom_range(0, 19) == 0)
                rp = IM_BASE + (32'd4 << IM_AW) - 32'd8;
            else
                rp = IM_BASE + $urandom_range(0, 16383);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), rp,
                ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
